stopwatch_timer_ctrl: RTL and testbench
=======================================

Name: stopwatch_timer_ctrl

Overview:
Front-panel controller for the stopwatch_timer datapath. It debounces five raw push-buttons and runs the IDLE/RUN/PAUSE/SET/EXPIRED state machine. It holds the timer preset digits and drives the datapath's start, load, load_* digit and clear inputs. It sits between the board buttons and stopwatch_timer, and consumes that block's done flag.

Parameters:
CLK_FREQ, 100000000, clock frequency in Hz; passed through for consistency with the datapath.
DEB_CYCLES, CLK_FREQ/100, number of consecutive cycles a synchronised button must be stable before its debounced level changes (10 ms).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_ss  input  1  raw start/stop button, asynchronous
btn_mode  input  1  raw mode button: 0 = stopwatch, 1 = timer
btn_clr  input  1  raw clear button
btn_set  input  1  raw set/next-digit button
btn_inc  input  1  raw digit-increment button
done  input  1  countdown-expired flag from the datapath
mode  output  1  current mode, 0 = stopwatch, 1 = timer
start  output  1  datapath count enable (level)
load  output  1  one-cycle preset load strobe
clr_out  output  1  one-cycle synchronous datapath clear strobe
load_min_tens  output  4  preset digit, range 0-9
load_min_ones  output  4  preset digit, range 0-9
load_sec_tens  output  4  preset digit, range 0-5
load_sec_ones  output  4  preset digit, range 0-9
edit_digit  output  2  digit under edit: 3 = min_tens, 2 = min_ones, 1 = sec_tens, 0 = sec_ones
alarm  output  1  high while in EXPIRED

Behaviour:
- Reset (async, rst=1): state IDLE, mode=0, all preset digits 0, start=0, load=0, clr_out=0, alarm=0, edit_digit=0, debouncers cleared to released.
- Button path: 2-FF synchroniser → stability counter (DEB_CYCLES) → debounced level → rising-edge detect → one-cycle press pulse. Release generates no pulse. A held button gives exactly one pulse.
- Press priority in one cycle: clr > ss > mode > set > inc. Only the winner is acted on; the others are dropped.
- Latency: the press pulse is seen at cycle N; state and all outputs change at cycle N+1 (registered outputs).
- load_* outputs are continuously driven from the preset registers.
- load and clr_out are each exactly one cycle wide and never asserted together. start=0 in any cycle where load or clr_out is 1.
- IDLE (start=0):
  - ss → RUN. In timer mode with preset 00:00, stay in IDLE.
  - mode → toggle mode, pulse clr_out.
  - set → SET with edit_digit=3, timer mode only; ignored in stopwatch mode.
  - clr → pulse clr_out in stopwatch mode; pulse load in timer mode.
  - inc → ignored.
- RUN (start=1):
  - ss → PAUSE.
  - done=1 while mode=1 → EXPIRED.
  - clr, mode, set, inc → ignored.
- PAUSE (start=0):
  - ss → RUN.
  - clr → IDLE, with clr_out (stopwatch) or load (timer).
  - Others ignored.
- SET (start=0):
  - inc → selected digit +1, wrapping 9→0; sec_tens wraps 5→0.
  - set → edit_digit-1. A set at edit_digit=0 pulses load and goes to IDLE.
  - clr → all preset digits 0, remain in SET.
  - ss, mode → ignored.
- EXPIRED (start=0, alarm=1):
  - ss or clr → pulse load (reload preset), go to IDLE, alarm=0.
  - done is ignored in every state other than RUN.
- Reset asserted mid-RUN/SET: immediate return to reset values; preset is lost.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum {IDLE, RUN, PAUSE, SET, EXPIRED};
  - digit-index constants DIG_MT=3, DIG_MO=2, DIG_ST=1, DIG_SO=0;
  - digit maxima 9 and 5.
- One sub-module, btn_debounce (synchroniser, stability counter, edge pulse; parameter DEB_CYCLES), instantiated five times.

Test Plan:
Run with CLK_FREQ=10 and DEB_CYCLES=3; a press = button high for 6 cycles.
1. Reset, then press ss → start=1 at 5th cycle after rising input (2 sync + 3 stable - 1 + 1 reg); second press → start=0, state PAUSE; clr → clr_out one cycle, state IDLE.
2. Bounce btn_ss 1-0-1-0 at 1-cycle spacing, then hold → exactly one press pulse; start toggles once.
3. mode → mode=1, clr_out pulse. Then: set, inc×1 (min_tens=1), set, set, inc×7 (sec_tens wraps 0→6? no: 0..5 then 0, ends at 1), set, inc×5, set → load pulse with load digits 1,0,1,5, state IDLE.
4. Timer mode, preset 00:00, press ss → start stays 0, state IDLE.
5. Timer running with preset 00:05; drive done=1 → start=0, alarm=1 next cycle. Press clr → load one cycle, alarm=0, IDLE.
6. btn_clr and btn_ss pressed in the same cycle while in RUN → clr wins and is ignored in RUN, ss dropped: start stays 1. In PAUSE: IDLE plus clr_out, not RUN.

Source files
------------

// File: rtl/stopwatch_timer_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg                                                        |
// | Shared FSM states, digit indices and digit limits for the controller.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    SET     = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  localparam logic [1:0] DIG_MT = 2'd3;
  localparam logic [1:0] DIG_MO = 2'd2;
  localparam logic [1:0] DIG_ST = 2'd1;
  localparam logic [1:0] DIG_SO = 2'd0;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max_v);
    return (d >= max_v) ? 4'd0 : d + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_timer_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce                                                         |
// | 2-FF synchroniser, stability counter and one-cycle press pulse.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // The cycle in which the new level is adopted counts as the last stable one,
  // so the change lands DEB_CYCLES-1 edges after the synchronised value moved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pulse = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/stopwatch_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_timer_ctrl                                                 |
// | Button debouncing and IDLE/RUN/PAUSE/SET/EXPIRED front-panel FSM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stopwatch_timer_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int DEB_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_mode,
  input  logic       btn_clr,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       done,
  output logic       mode,
  output logic       start,
  output logic       load,
  output logic       clr_out,
  output logic [3:0] load_min_tens,
  output logic [3:0] load_min_ones,
  output logic [3:0] load_sec_tens,
  output logic [3:0] load_sec_ones,
  output logic [1:0] edit_digit,
  output logic       alarm
);

  localparam int BTN_CLR  = 0;
  localparam int BTN_SS   = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_SET  = 3;
  localparam int BTN_INC  = 4;

  logic [4:0] w_raw;
  logic [4:0] w_press;
  logic       w_clr, w_ss, w_mode, w_set, w_inc;
  logic       w_preset_zero;

  state_t     r_state;
  logic       r_mode, r_start, r_load, r_clr, r_alarm;
  logic [1:0] r_edit;
  logic [3:0] r_mt, r_mo, r_st, r_so;

  assign w_raw = {btn_inc, btn_set, btn_mode, btn_ss, btn_clr};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (w_raw[i]),
      .pulse (w_press[i])
    );
  end

  // Single-winner arbitration: clr > ss > mode > set > inc.
  assign w_clr  = w_press[BTN_CLR];
  assign w_ss   = w_press[BTN_SS]   & ~w_press[BTN_CLR];
  assign w_mode = w_press[BTN_MODE] & ~|w_press[BTN_SS:BTN_CLR];
  assign w_set  = w_press[BTN_SET]  & ~|w_press[BTN_MODE:BTN_CLR];
  assign w_inc  = w_press[BTN_INC]  & ~|w_press[BTN_SET:BTN_CLR];

  assign w_preset_zero = ({r_mt, r_mo, r_st, r_so} == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_start <= 1'b0;
      r_load  <= 1'b0;
      r_clr   <= 1'b0;
      r_alarm <= 1'b0;
      r_edit  <= DIG_SO;
      r_mt    <= 4'd0;
      r_mo    <= 4'd0;
      r_st    <= 4'd0;
      r_so    <= 4'd0;
    end else begin
      r_load <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_clr) begin
            r_load <= r_mode;
            r_clr  <= ~r_mode;
          end else if (w_ss) begin
            if (!(r_mode && w_preset_zero)) begin
              r_state <= RUN;
              r_start <= 1'b1;
            end
          end else if (w_mode) begin
            r_mode <= ~r_mode;
            r_clr  <= 1'b1;
          end else if (w_set && r_mode) begin
            r_state <= SET;
            r_edit  <= DIG_MT;
          end
        end
        RUN: begin
          if (done && r_mode) begin
            r_state <= EXPIRED;
            r_start <= 1'b0;
            r_alarm <= 1'b1;
          end else if (w_ss) begin
            r_state <= PAUSE;
            r_start <= 1'b0;
          end
        end
        PAUSE: begin
          if (w_clr) begin
            r_state <= IDLE;
            r_load  <= r_mode;
            r_clr   <= ~r_mode;
          end else if (w_ss) begin
            r_state <= RUN;
            r_start <= 1'b1;
          end
        end
        SET: begin
          if (w_clr) begin
            r_mt <= 4'd0;
            r_mo <= 4'd0;
            r_st <= 4'd0;
            r_so <= 4'd0;
          end else if (w_set) begin
            if (r_edit == DIG_SO) begin
              r_state <= IDLE;
              r_load  <= 1'b1;
            end else begin
              r_edit <= r_edit - 2'd1;
            end
          end else if (w_inc) begin
            case (r_edit)
              DIG_MT:  r_mt <= digit_inc(r_mt, DIGIT_MAX);
              DIG_MO:  r_mo <= digit_inc(r_mo, DIGIT_MAX);
              DIG_ST:  r_st <= digit_inc(r_st, SEC_TENS_MAX);
              default: r_so <= digit_inc(r_so, DIGIT_MAX);
            endcase
          end
        end
        EXPIRED: begin
          if (w_clr || w_ss) begin
            r_state <= IDLE;
            r_load  <= 1'b1;
            r_alarm <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_start <= 1'b0;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign mode          = r_mode;
  assign start         = r_start;
  assign load          = r_load;
  assign clr_out       = r_clr;
  assign alarm         = r_alarm;
  assign edit_digit    = r_edit;
  assign load_min_tens = r_mt;
  assign load_min_ones = r_mo;
  assign load_sec_tens = r_st;
  assign load_sec_ones = r_so;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stopwatch_timer_ctrl                                              |
// | Directed bench with a pulse scoreboard for the front-panel FSM.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_stopwatch_timer_ctrl;

  localparam logic [4:0] B_CLR  = 5'b00001;
  localparam logic [4:0] B_SS   = 5'b00010;
  localparam logic [4:0] B_MODE = 5'b00100;
  localparam logic [4:0] B_SET  = 5'b01000;
  localparam logic [4:0] B_INC  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss, btn_mode, btn_clr, btn_set, btn_inc, done;
  logic       mode, start, load, clr_out, alarm;
  logic [3:0] load_min_tens, load_min_ones, load_sec_tens, load_sec_ones;
  logic [1:0] edit_digit;

  typedef struct {
    bit         is_load;
    logic [15:0] digits;
    int         cyc;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] em_mt = 0, em_mo = 0, em_st = 0, em_so = 0;

  stopwatch_timer_ctrl #(.CLK_FREQ(10), .DEB_CYCLES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_ss        (btn_ss),
    .btn_mode      (btn_mode),
    .btn_clr       (btn_clr),
    .btn_set       (btn_set),
    .btn_inc       (btn_inc),
    .done          (done),
    .mode          (mode),
    .start         (start),
    .load          (load),
    .clr_out       (clr_out),
    .load_min_tens (load_min_tens),
    .load_min_ones (load_min_ones),
    .load_sec_tens (load_sec_tens),
    .load_sec_ones (load_sec_ones),
    .edit_digit    (edit_digit),
    .alarm         (alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] em_digits();
    return {em_mt, em_mo, em_st, em_so};
  endfunction

  // pk: 0 = no strobe expected, 1 = clr_out expected, 2 = load expected
  task automatic press(input logic [4:0] m, input int pk, input bit chk_lat);
    ev_t e;
    if (pk != 0) begin
      e.is_load = (pk == 2);
      e.digits  = em_digits();
      e.cyc     = cyc + 5;
      exp_q.push_back(e);
    end
    {btn_inc, btn_set, btn_mode, btn_ss, btn_clr} = m;
    if (chk_lat) begin
      repeat (4) @(posedge clk);
      #1 chk("latency_start_early", start, 1'b0);
      @(posedge clk);
      #1 chk("latency_start_on_time", start, 1'b1);
      @(posedge clk);
      #1;
    end else begin
      repeat (6) @(posedge clk);
      #1;
    end
    {btn_inc, btn_set, btn_mode, btn_ss, btn_clr} = 5'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && (load || clr_out)) begin
      chk("load_clr_exclusive", load & clr_out, 1'b0);
      chk("start_low_on_strobe", start, 1'b0);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed load=%0b clr_out=%0b expected none", load, clr_out);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind_load", load, mon_e.is_load);
        chk("strobe_kind_clr", clr_out, !mon_e.is_load);
        chk("strobe_digits", {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones}, mon_e.digits);
        chk("strobe_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    {btn_inc, btn_set, btn_mode, btn_ss, btn_clr} = 5'b0;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start, 1'b0);
    chk("rst_mode", mode, 1'b0);
    chk("rst_load", load, 1'b0);
    chk("rst_clr_out", clr_out, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_edit", edit_digit, 2'd0);
    chk("rst_digits", {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones}, 16'h0000);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // stopwatch start / pause / clear
    press(B_SS, 0, 1'b1);
    press(B_SS, 0, 1'b0);
    chk("pause_start", start, 1'b0);
    press(B_CLR, 1, 1'b0);
    chk("idle_after_clr", start, 1'b0);

    // bounced start button gives a single press
    btn_ss = 1'b1; @(posedge clk); #1;
    btn_ss = 1'b0; @(posedge clk); #1;
    btn_ss = 1'b1; @(posedge clk); #1;
    btn_ss = 1'b0; @(posedge clk); #1;
    press(B_SS, 0, 1'b0);
    chk("bounce_single_toggle", start, 1'b1);
    press(B_SS, 0, 1'b0);
    press(B_CLR, 1, 1'b0);

    // timer mode, edit preset to 10:15
    press(B_MODE, 1, 1'b0);
    chk("mode_timer", mode, 1'b1);
    press(B_SET, 0, 1'b0);
    chk("edit_mt", edit_digit, 2'd3);
    press(B_INC, 0, 1'b0);
    em_mt = 4'd1;
    chk("min_tens_inc", load_min_tens, em_mt);
    press(B_SET, 0, 1'b0);
    press(B_SET, 0, 1'b0);
    chk("edit_st", edit_digit, 2'd1);
    for (int i = 0; i < 7; i++) press(B_INC, 0, 1'b0);
    em_st = 4'd1;
    chk("sec_tens_wrap", load_sec_tens, em_st);
    press(B_SET, 0, 1'b0);
    for (int i = 0; i < 5; i++) press(B_INC, 0, 1'b0);
    em_so = 4'd5;
    press(B_SET, 2, 1'b0);
    chk("preset_1015", {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones}, 16'h1015);
    chk("set_exit_start", start, 1'b0);

    // zero preset blocks timer start
    press(B_SET, 0, 1'b0);
    press(B_CLR, 0, 1'b0);
    em_mt = 4'd0; em_st = 4'd0; em_so = 4'd0;
    chk("set_clr_digits", {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones}, 16'h0000);
    chk("set_clr_edit", edit_digit, 2'd3);
    for (int i = 0; i < 3; i++) press(B_SET, 0, 1'b0);
    press(B_SET, 2, 1'b0);
    press(B_SS, 0, 1'b0);
    chk("zero_preset_no_start", start, 1'b0);

    // 00:05 countdown then expiry
    for (int i = 0; i < 4; i++) press(B_SET, 0, 1'b0);
    chk("edit_so", edit_digit, 2'd0);
    for (int i = 0; i < 5; i++) press(B_INC, 0, 1'b0);
    em_so = 4'd5;
    press(B_SET, 2, 1'b0);
    press(B_SS, 0, 1'b0);
    chk("timer_run", start, 1'b1);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("expired_start", start, 1'b0);
    chk("expired_alarm", alarm, 1'b1);
    press(B_CLR, 2, 1'b0);
    chk("alarm_cleared", alarm, 1'b0);
    done = 1'b1;
    repeat (2) @(posedge clk); #1;
    done = 1'b0;
    chk("done_ignored_idle", alarm, 1'b0);

    // stopwatch: simultaneous clr+ss
    press(B_MODE, 1, 1'b0);
    chk("mode_stopwatch", mode, 1'b0);
    press(B_SS, 0, 1'b0);
    done = 1'b1;
    repeat (2) @(posedge clk); #1;
    done = 1'b0;
    chk("done_ignored_stopwatch", start, 1'b1);
    press(B_CLR | B_SS, 0, 1'b0);
    chk("clr_ss_in_run", start, 1'b1);
    press(B_SS, 0, 1'b0);
    press(B_CLR | B_SS, 1, 1'b0);
    chk("clr_ss_in_pause", start, 1'b0);
    press(B_SS, 0, 1'b0);
    chk("restart_after_idle", start, 1'b1);

    // asynchronous reset mid-run
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_start", start, 1'b0);
    chk("async_rst_digits", {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
